periph_bus_initiator: RTL

- Master end of the cluster peripheral bus (XBAR_PERIPH_BUS signal set: req/add/wen/wdata/be/id, gnt, r_valid/r_opc/r_id/r_rdata).
- Accepts single-beat commands on a valid/ready stream and drives them onto the bus with the req/gnt handshake.
- Tracks outstanding transactions and returns responses through a credit-protected response FIFO.
- Used by cluster-side engines (boot sequencer, debug/test access) that program cluster peripherals the same way cores do.

---
 rtl/periph_bus_initiator.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/periph_bus_initiator.sv
// rtl/periph_bus_initiator.sv - peripheral bus initiator: command stream to req/gnt bus, credit-protected response FIFO
// Optional watchdog enabled by defining PERIPH_INITIATOR_TIMEOUT_EN.
module periph_bus_initiator #(
   parameter int ID_WIDTH       = 5,
   parameter int MASTER_ID      = 0,
   parameter int RESP_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [31:0]         cmd_add_i,
   input  logic                cmd_wen_i,
   input  logic [31:0]         cmd_wdata_i,
   input  logic [3:0]          cmd_be_i,
   output logic                per_req_o,
   output logic [31:0]         per_add_o,
   output logic                per_wen_o,
   output logic [31:0]         per_wdata_o,
   output logic [3:0]          per_be_o,
   output logic [ID_WIDTH-1:0] per_id_o,
   input  logic                per_gnt_i,
   input  logic                per_r_valid_i,
   input  logic                per_r_opc_i,
   input  logic [ID_WIDTH-1:0] per_r_id_i,
   input  logic [31:0]         per_r_rdata_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [31:0]         rsp_rdata_o,
   output logic                rsp_opc_o,
   output logic                busy_o,
   output logic                timeout_o
);

   localparam int PW = $clog2(RESP_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(RESP_DEPTH);
   localparam logic [ID_WIDTH-1:0] ID_ONE = ID_WIDTH'(1) << MASTER_ID;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t        state_q, state_d;
   logic          run_q;
   logic          accept, grant;
   logic [CW-1:0] in_flight, fifo_count;
   logic [CW:0]   occupancy;
   logic          credit_ok;
   logic          rsp_hit, pop, push, real_push, syn_push, can_push, full, dec;
   logic [32:0]   push_data;
   logic [32:0]   mem [RESP_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          unused_id;

   assign unused_id = ^per_r_id_i;

   // Outstanding bus transactions plus queued responses must fit in the FIFO.
   assign occupancy = {1'b0, in_flight} + {1'b0, fifo_count};
   assign credit_ok = occupancy < DEPTH_W;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      grant       = 1'b0;
      cmd_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready_o = run_q & credit_ok;
            if (cmd_valid_i && cmd_ready_o) begin
               accept  = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (per_gnt_i) begin
               grant   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign per_req_o = (state_q == REQ);
   assign busy_o    = (state_q == REQ) | (in_flight != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         per_add_o   <= '0;
         per_wen_o   <= 1'b0;
         per_wdata_o <= '0;
         per_be_o    <= '0;
         per_id_o    <= '0;
      end else if (accept) begin
         per_add_o   <= cmd_add_i;
         per_wen_o   <= cmd_wen_i;
         per_wdata_o <= cmd_wdata_i;
         per_be_o    <= cmd_be_i;
         per_id_o    <= ID_ONE;
      end
   end

   assign rsp_hit   = per_r_valid_i & per_r_id_i[MASTER_ID];
   assign full      = (fifo_count == DEPTH_C);
   assign pop       = rsp_valid_o & rsp_ready_i;
   assign can_push  = ~full | pop;
   assign real_push = rsp_hit & can_push;
   assign push      = real_push | syn_push;
   assign push_data = rsp_hit ? {per_r_opc_i, per_r_rdata_i} : {1'b1, 32'hDEAD_BEEF};
   assign dec       = (rsp_hit | syn_push) & (in_flight != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in_flight  <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         if (grant && !dec)
            in_flight <= in_flight + 1'b1;
         else if (!grant && dec)
            in_flight <= in_flight - 1'b1;
         if (push && !pop)
            fifo_count <= fifo_count + 1'b1;
         else if (pop && !push)
            fifo_count <= fifo_count - 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   assign rsp_valid_o = (fifo_count != '0);
   assign rsp_rdata_o = rsp_valid_o ? mem[rd_ptr][31:0] : 32'h0;
   assign rsp_opc_o   = rsp_valid_o ? mem[rd_ptr][32] : 1'b0;

   // A response landing on a full FIFO means the slave broke the credit contract.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(rsp_hit && !can_push));

`ifdef PERIPH_INITIATOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt;
   logic          to_pend, timeout_q, count_en, fire;

   assign count_en  = (in_flight != '0) & ~rsp_hit & ~to_pend;
   assign fire      = count_en & (to_cnt == TO_LAST);
   assign syn_push  = (fire | to_pend) & ~rsp_hit & can_push;
   assign timeout_o = timeout_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt    <= '0;
         to_pend   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt  <= (count_en && !fire) ? to_cnt + 1'b1 : '0;
         to_pend <= (fire | to_pend) & ~syn_push;
         if (fire)
            timeout_q <= 1'b1;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign syn_push  = 1'b0;
   assign timeout_o = 1'b0;
`endif

endmodule
